// File: rtl/rob_mp_queue.sv
// rob_mp_queue: reorder buffer with in-order sequence-number allocation,
// p_num_ins parallel out-of-order completion ports and an in-order
// ready/valid dequeue of the head entry.
// Handshakes: alloc fires when alloc_en & alloc_rdy at posedge; insert port k
// fires when ins_cpl[k] (combinational accept) at posedge; dequeue fires when
// deq_en & deq_front_cpl at posedge.
// Optional: define ROB_MP_FLUSH_EN to add a synchronous flush input.
module rob_mp_queue #(
    parameter int p_depth    = 32,
    parameter int p_ptrwidth = $clog2(p_depth),
    parameter int p_bitwidth = 32,
    parameter int p_num_ins  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef ROB_MP_FLUSH_EN
    input  logic                            flush,
`endif
    input  logic                            alloc_en,
    output logic                            alloc_rdy,
    output logic [p_ptrwidth-1:0]           alloc_sn,
    input  logic [p_num_ins-1:0]            ins_en,
    input  logic [p_num_ins*p_ptrwidth-1:0] ins_sn_in,
    input  logic [p_num_ins*p_bitwidth-1:0] ins_data_in,
    output logic [p_num_ins-1:0]            ins_cpl,
    output logic                            deq_front_cpl,
    output logic [p_bitwidth-1:0]           deq_front_data,
    input  logic                            deq_en,
    output logic [p_ptrwidth:0]             count
);

    localparam logic [p_ptrwidth:0]   depth_c = (p_ptrwidth+1)'(p_depth);
    localparam logic [p_ptrwidth-1:0] one_c   = p_ptrwidth'(1);

    logic [p_ptrwidth-1:0] head_q;
    logic [p_ptrwidth-1:0] tail_q;
    logic [p_ptrwidth:0]   count_q;
    logic [p_depth-1:0]    alloc_q;
    logic [p_depth-1:0]    cpl_q;
    logic [p_bitwidth-1:0] data_q [p_depth];

    logic [p_ptrwidth-1:0] sn  [p_num_ins];
    logic [p_bitwidth-1:0] pay [p_num_ins];

    logic                  flush_act;
    logic                  alloc_fire;
    logic                  deq_fire;
    logic                  pt_hit;
    logic [p_bitwidth-1:0] pt_data;

`ifdef ROB_MP_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign alloc_rdy  = (count_q != depth_c);
    assign alloc_sn   = tail_q;
    assign count      = count_q;
    assign alloc_fire = alloc_en & alloc_rdy & ~flush_act;
    assign deq_fire   = deq_en & deq_front_cpl;

    // Split the flat per-port buses into per-port sequence numbers and payloads.
    always_comb begin
        for (int k = 0; k < p_num_ins; k++) begin
            sn[k]  = ins_sn_in[k*p_ptrwidth +: p_ptrwidth];
            pay[k] = ins_data_in[k*p_bitwidth +: p_bitwidth];
        end
    end

    // Accept an insert only into a live, not-yet-complete entry; when several
    // ports target the same entry the lowest-indexed one wins.
    always_comb begin
        logic ok;
        ins_cpl = '0;
        ok      = 1'b0;
        for (int k = 0; k < p_num_ins; k++) begin
            ok = ins_en[k] & alloc_q[sn[k]] & ~cpl_q[sn[k]] & ~flush_act;
            for (int j = 0; j < k; j++) begin
                if (ins_en[j] && (sn[j] == sn[k])) begin
                    ok = 1'b0;
                end
            end
            ins_cpl[k] = ok;
        end
    end

    // Head view: a same-cycle accepted insert into the head bypasses the array.
    always_comb begin
        pt_hit  = 1'b0;
        pt_data = data_q[head_q];
        for (int k = p_num_ins - 1; k >= 0; k--) begin
            if (ins_cpl[k] && (sn[k] == head_q)) begin
                pt_hit  = 1'b1;
                pt_data = pay[k];
            end
        end
        deq_front_cpl  = (cpl_q[head_q] & ~flush_act) | pt_hit;
        deq_front_data = pt_hit ? pt_data : data_q[head_q];
    end

    // Pointers, occupancy and per-entry status; a dequeue clears the head
    // after any same-cycle insert so a passthrough entry is freed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            cpl_q   <= '0;
        end else if (flush_act) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            cpl_q   <= '0;
        end else begin
            if (alloc_fire) begin
                alloc_q[tail_q] <= 1'b1;
                cpl_q[tail_q]   <= 1'b0;
                tail_q          <= tail_q + one_c;
            end
            for (int k = 0; k < p_num_ins; k++) begin
                if (ins_cpl[k]) begin
                    cpl_q[sn[k]] <= 1'b1;
                end
            end
            if (deq_fire) begin
                alloc_q[head_q] <= 1'b0;
                cpl_q[head_q]   <= 1'b0;
                head_q          <= head_q + one_c;
            end
            count_q <= count_q + {{p_ptrwidth{1'b0}}, alloc_fire}
                               - {{p_ptrwidth{1'b0}}, deq_fire};
        end
    end

    // Payload storage; cleared on reset so the head data reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < p_depth; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < p_num_ins; k++) begin
                if (ins_cpl[k]) begin
                    data_q[sn[k]] <= pay[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_mp_queue.sv
// Testbench for rob_mp_queue (p_depth=8, two insert ports). The reference
// model tracks the ROB as a window [head, head+count) with per-slot
// completion flags and payloads.
module tb_rob_mp_queue;

    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int BW    = 32;
    localparam int NI    = 2;

    logic              clk;
    logic              rst;
`ifdef ROB_MP_FLUSH_EN
    logic              flush;
`endif
    logic              alloc_en;
    logic              alloc_rdy;
    logic [PW-1:0]     alloc_sn;
    logic [NI-1:0]     ins_en;
    logic [NI*PW-1:0]  ins_sn_in;
    logic [NI*BW-1:0]  ins_data_in;
    logic [NI-1:0]     ins_cpl;
    logic              deq_front_cpl;
    logic [BW-1:0]     deq_front_data;
    logic              deq_en;
    logic [PW:0]       count;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] exp_q[$];

    // reference model state
    int            m_head;
    int            m_count;
    logic          m_cpl  [DEPTH];
    logic [BW-1:0] m_data [DEPTH];

    // model predictions for the current cycle
    logic          e_alloc_rdy;
    logic [PW-1:0] e_alloc_sn;
    logic [NI-1:0] e_ins_cpl;
    logic          e_front_cpl;
    logic [BW-1:0] e_front_data;
    logic [PW:0]   e_count;

    rob_mp_queue #(
        .p_depth   (DEPTH),
        .p_ptrwidth(PW),
        .p_bitwidth(BW),
        .p_num_ins (NI)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef ROB_MP_FLUSH_EN
        .flush         (flush),
`endif
        .alloc_en      (alloc_en),
        .alloc_rdy     (alloc_rdy),
        .alloc_sn      (alloc_sn),
        .ins_en        (ins_en),
        .ins_sn_in     (ins_sn_in),
        .ins_data_in   (ins_data_in),
        .ins_cpl       (ins_cpl),
        .deq_front_cpl (deq_front_cpl),
        .deq_front_data(deq_front_data),
        .deq_en        (deq_en),
        .count         (count)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic int rel(int s);
        return (s - m_head + DEPTH) % DEPTH;
    endfunction

    function automatic int port_sn(int k);
        return int'(ins_sn_in[k*PW +: PW]);
    endfunction

    task automatic model_reset();
        m_head  = 0;
        m_count = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_cpl[i]  = 1'b0;
            m_data[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_eval();
        bit fl;
        fl = 1'b0;
`ifdef ROB_MP_FLUSH_EN
        fl = flush;
`endif
        e_alloc_rdy = (m_count != DEPTH);
        e_alloc_sn  = PW'((m_head + m_count) % DEPTH);
        e_count     = (PW+1)'(m_count);
        e_ins_cpl   = '0;
        for (int k = 0; k < NI; k++) begin
            int s;
            bit ok;
            s  = port_sn(k);
            ok = ins_en[k] && (rel(s) < m_count) && !m_cpl[s] && !fl;
            for (int j = 0; j < k; j++) begin
                if (ins_en[j] && port_sn(j) == s) ok = 1'b0;
            end
            e_ins_cpl[k] = ok;
        end
        e_front_cpl  = 1'b0;
        e_front_data = '0;
        if (!fl && m_count > 0 && m_cpl[m_head]) begin
            e_front_cpl  = 1'b1;
            e_front_data = m_data[m_head];
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (!e_front_cpl && e_ins_cpl[k] && port_sn(k) == m_head) begin
                    e_front_cpl  = 1'b1;
                    e_front_data = ins_data_in[k*BW +: BW];
                end
            end
        end
    endtask

    task automatic model_commit();
        int t;
        t = (m_head + m_count) % DEPTH;
`ifdef ROB_MP_FLUSH_EN
        if (flush) begin
            m_head  = 0;
            m_count = 0;
            for (int i = 0; i < DEPTH; i++) m_cpl[i] = 1'b0;
            return;
        end
`endif
        for (int k = 0; k < NI; k++) begin
            if (e_ins_cpl[k]) begin
                m_cpl[port_sn(k)]  = 1'b1;
                m_data[port_sn(k)] = ins_data_in[k*BW +: BW];
            end
        end
        if (deq_en && e_front_cpl) begin
            m_cpl[m_head] = 1'b0;
            m_head        = (m_head + 1) % DEPTH;
            m_count       = m_count - 1;
        end
        if (alloc_en && e_alloc_rdy) begin
            m_cpl[t] = 1'b0;
            m_count  = m_count + 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        alloc_en    = 1'b0;
        deq_en      = 1'b0;
        ins_en      = '0;
        ins_sn_in   = '0;
        ins_data_in = '0;
`ifdef ROB_MP_FLUSH_EN
        flush       = 1'b0;
`endif
    endtask

    task automatic set_port(int k, bit en, int s, logic [BW-1:0] d);
        ins_en[k]              = en;
        ins_sn_in[k*PW +: PW]  = PW'(s);
        ins_data_in[k*BW +: BW] = d;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_alloc(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_idle();
            alloc_en = 1'b1;
            settle();
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #2;
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL reset_alloc_rdy got %b exp 1", alloc_rdy); end
        checks++; if (alloc_sn !== 3'd0) begin errors++; $display("FAIL reset_alloc_sn got %0d exp 0", alloc_sn); end
        checks++; if (ins_cpl !== 2'b00) begin errors++; $display("FAIL reset_ins_cpl got %b exp 00", ins_cpl); end
        checks++; if (deq_front_cpl !== 1'b0) begin errors++; $display("FAIL reset_front_cpl got %b exp 0", deq_front_cpl); end
        checks++; if (deq_front_data !== 32'd0) begin errors++; $display("FAIL reset_front_data got %h exp 0", deq_front_data); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_alloc_fill();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            set_idle();
            alloc_en = 1'b1;
            settle();
            checks++; if (alloc_sn !== PW'(i)) begin errors++; $display("FAIL fill_alloc_sn got %0d exp %0d", alloc_sn, i); end
            checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL fill_alloc_rdy got %b exp 1", alloc_rdy); end
            tick();
        end
        @(negedge clk);
        alloc_en = 1'b1;
        settle();
        checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL full_alloc_rdy got %b exp 0", alloc_rdy); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
        tick();
        @(negedge clk);
        set_idle();
        settle();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_ignored_count got %0d exp 8", count); end
        checks++; if (alloc_sn !== e_alloc_sn) begin errors++; $display("FAIL full_ignored_sn got %0d exp %0d", alloc_sn, e_alloc_sn); end
    endtask

    task automatic test_ooo_insert();
        for (int s = 7; s >= 1; s--) begin
            @(negedge clk);
            set_idle();
            set_port(0, 1'b1, s, 32'hA0 + 32'(s));
            settle();
            checks++; if (ins_cpl !== 2'b01) begin errors++; $display("FAIL ooo_ins_cpl sn %0d got %b exp 01", s, ins_cpl); end
            checks++; if (deq_front_cpl !== 1'b0) begin errors++; $display("FAIL ooo_front_cpl sn %0d got %b exp 0", s, deq_front_cpl); end
            tick();
        end
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < DEPTH; i++) begin
            logic [BW-1:0] want;
            @(negedge clk);
            set_idle();
            if (i == 0) set_port(0, 1'b1, 0, 32'hA0);
            deq_en = 1'b1;
            settle();
            want = exp_q.pop_front();
            checks++; if (deq_front_cpl !== 1'b1) begin errors++; $display("FAIL drain_front_cpl %0d got %b exp 1", i, deq_front_cpl); end
            checks++; if (deq_front_data !== want) begin errors++; $display("FAIL drain_data %0d got %h exp %h", i, deq_front_data, want); end
            tick();
        end
        @(negedge clk);
        set_idle();
        settle();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
        checks++; if (deq_front_cpl !== 1'b0) begin errors++; $display("FAIL drain_empty_cpl got %b exp 0", deq_front_cpl); end
    endtask

    task automatic test_same_sn();
        do_alloc(4);
        @(negedge clk);
        set_idle();
        set_port(0, 1'b1, 3, 32'h33);
        set_port(1, 1'b1, 3, 32'h44);
        settle();
        checks++; if (ins_cpl !== 2'b01) begin errors++; $display("FAIL same_sn_cpl got %b exp 01", ins_cpl); end
        tick();
        @(negedge clk);
        set_idle();
        set_port(0, 1'b1, 6, 32'h66);
        set_port(1, 1'b1, 3, 32'h44);
        settle();
        checks++; if (ins_cpl !== 2'b00) begin errors++; $display("FAIL reject_cpl got %b exp 00", ins_cpl); end
        tick();
        @(negedge clk);
        set_idle();
        set_port(0, 1'b1, 0, 32'h30);
        set_port(1, 1'b1, 1, 32'h31);
        settle();
        checks++; if (ins_cpl !== 2'b11) begin errors++; $display("FAIL dual_ins_cpl got %b exp 11", ins_cpl); end
        checks++; if (deq_front_data !== 32'h30 || deq_front_cpl !== 1'b1) begin errors++; $display("FAIL passthrough got %b/%h exp 1/30", deq_front_cpl, deq_front_data); end
        tick();
        exp_q = '{32'h30, 32'h31, 32'h32, 32'h33};
        for (int i = 0; i < 4; i++) begin
            logic [BW-1:0] want;
            @(negedge clk);
            set_idle();
            if (i == 0) set_port(0, 1'b1, 2, 32'h32);
            deq_en = 1'b1;
            settle();
            want = exp_q.pop_front();
            checks++; if (deq_front_data !== want || deq_front_cpl !== 1'b1) begin errors++; $display("FAIL same_sn_drain %0d got %b/%h exp 1/%h", i, deq_front_cpl, deq_front_data, want); end
            tick();
        end
    endtask

    task automatic test_count_simul();
        do_alloc(5);
        @(negedge clk);
        set_idle();
        set_port(0, 1'b1, m_head, 32'h55);
        settle();
        tick();
        @(negedge clk);
        set_idle();
        alloc_en = 1'b1;
        deq_en   = 1'b1;
        settle();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL simul_pre_count got %0d exp 5", count); end
        tick();
        @(negedge clk);
        set_idle();
        settle();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL simul_count got %0d exp 5", count); end
        checks++; if (alloc_sn !== e_alloc_sn) begin errors++; $display("FAIL simul_alloc_sn got %0d exp %0d", alloc_sn, e_alloc_sn); end
        do_alloc(3);
        @(negedge clk);
        set_idle();
        set_port(0, 1'b1, m_head, 32'h66);
        settle();
        tick();
        @(negedge clk);
        set_idle();
        alloc_en = 1'b1;
        deq_en   = 1'b1;
        settle();
        checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL full_deq_alloc_rdy got %b exp 0", alloc_rdy); end
        tick();
        @(negedge clk);
        set_idle();
        settle();
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_deq_count got %0d exp 7", count); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        set_idle();
        set_port(0, 1'b1, m_head, 32'hBEEF);
        settle();
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_idle();
            settle();
            checks++; if (deq_front_cpl !== 1'b1 || deq_front_data !== 32'hBEEF) begin errors++; $display("FAIL hold_front %0d got %b/%h exp 1/0000beef", i, deq_front_cpl, deq_front_data); end
            checks++; if (count !== 4'd7) begin errors++; $display("FAIL hold_count %0d got %0d exp 7", i, count); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int r = 0; r < 20; r++) begin
            logic [BW-1:0] d;
            int            s;
            @(negedge clk);
            set_idle();
            alloc_en = 1'b1;
            settle();
            checks++; if (alloc_sn !== PW'(r % DEPTH)) begin errors++; $display("FAIL wrap_alloc_sn %0d got %0d exp %0d", r, alloc_sn, r % DEPTH); end
            s = r % DEPTH;
            tick();
            @(negedge clk);
            set_idle();
            d = $urandom;
            exp_q.push_back(d);
            set_port(r % 2, 1'b1, s, d);
            deq_en = 1'b1;
            settle();
            d = exp_q.pop_front();
            checks++; if (deq_front_cpl !== 1'b1 || deq_front_data !== d) begin errors++; $display("FAIL wrap_data %0d got %b/%h exp 1/%h", r, deq_front_cpl, deq_front_data, d); end
            tick();
        end
        @(negedge clk);
        set_idle();
        settle();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int s0;
            int s1;
            @(negedge clk);
            set_idle();
            alloc_en = ($urandom_range(0, 2) != 0);
            deq_en   = ($urandom_range(0, 3) != 0);
            s0 = (m_head + $urandom_range(0, DEPTH - 1)) % DEPTH;
            s1 = ($urandom_range(0, 3) == 0) ? s0 : (m_head + $urandom_range(0, DEPTH - 1)) % DEPTH;
            set_port(0, $urandom_range(0, 1), s0, $urandom);
            set_port(1, $urandom_range(0, 1), s1, $urandom);
            settle();
            checks++; if (alloc_rdy !== e_alloc_rdy) begin errors++; $display("FAIL rnd_alloc_rdy c%0d got %b exp %b", c, alloc_rdy, e_alloc_rdy); end
            checks++; if (alloc_sn !== e_alloc_sn) begin errors++; $display("FAIL rnd_alloc_sn c%0d got %0d exp %0d", c, alloc_sn, e_alloc_sn); end
            checks++; if (ins_cpl !== e_ins_cpl) begin errors++; $display("FAIL rnd_ins_cpl c%0d got %b exp %b", c, ins_cpl, e_ins_cpl); end
            checks++; if (deq_front_cpl !== e_front_cpl) begin errors++; $display("FAIL rnd_front_cpl c%0d got %b exp %b", c, deq_front_cpl, e_front_cpl); end
            checks++; if (count !== e_count) begin errors++; $display("FAIL rnd_count c%0d got %0d exp %0d", c, count, e_count); end
            if (e_front_cpl) begin
                checks++; if (deq_front_data !== e_front_data) begin errors++; $display("FAIL rnd_front_data c%0d got %h exp %h", c, deq_front_data, e_front_data); end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_alloc(3);
        @(negedge clk);
        set_idle();
        set_port(0, 1'b1, 1, 32'h77);
        settle();
        checks++; if (ins_cpl !== 2'b01) begin errors++; $display("FAIL pre_rst_ins_cpl got %b exp 01", ins_cpl); end
        #1 rst = 1'b1;
        #1;
        checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL arst_alloc_rdy got %b exp 1", alloc_rdy); end
        checks++; if (alloc_sn !== 3'd0) begin errors++; $display("FAIL arst_alloc_sn got %0d exp 0", alloc_sn); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", count); end
        checks++; if (ins_cpl !== 2'b00) begin errors++; $display("FAIL arst_ins_cpl got %b exp 00", ins_cpl); end
        checks++; if (deq_front_cpl !== 1'b0) begin errors++; $display("FAIL arst_front_cpl got %b exp 0", deq_front_cpl); end
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        model_reset();
    endtask

`ifdef ROB_MP_FLUSH_EN
    task automatic test_flush();
        apply_reset();
        do_alloc(4);
        @(negedge clk);
        set_idle();
        set_port(0, 1'b1, 0, 32'h11);
        settle();
        tick();
        @(negedge clk);
        set_idle();
        flush    = 1'b1;
        alloc_en = 1'b1;
        deq_en   = 1'b1;
        set_port(0, 1'b1, 1, 32'h12);
        settle();
        checks++; if (ins_cpl !== 2'b00) begin errors++; $display("FAIL flush_ins_cpl got %b exp 00", ins_cpl); end
        checks++; if (deq_front_cpl !== 1'b0) begin errors++; $display("FAIL flush_front_cpl got %b exp 0", deq_front_cpl); end
        tick();
        @(negedge clk);
        set_idle();
        settle();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL post_flush_count got %0d exp 0", count); end
        checks++; if (alloc_sn !== 3'd0) begin errors++; $display("FAIL post_flush_alloc_sn got %0d exp 0", alloc_sn); end
        checks++; if (deq_front_cpl !== 1'b0) begin errors++; $display("FAIL post_flush_front_cpl got %b exp 0", deq_front_cpl); end
    endtask
`endif

    // test sequence and final report
    initial begin
        rst = 1'b0;
        set_idle();
        model_reset();
        test_reset();
        test_alloc_fill();
        test_ooo_insert();
        test_same_sn();
        test_count_simul();
        test_hold();
        test_back_to_back();
        test_random();
        test_async_reset();
`ifdef ROB_MP_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
